// File: rtl/mem_byte_ctrl.sv
// Byte-serial load/store engine between the MEM stage and a byte-wide synchronous RAM.
// Splits each request into 1, 2 or 4 little-endian byte accesses and stalls the pipeline until done.
module mem_byte_ctrl #(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  req_ready,
  output logic                  stall_req,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_we,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, WAIT, DONE} state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] last;   // index of the final byte (byte count - 1)
  } size_t;

  state_t                state;
  logic [RAM_ADDR_W-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [2:0]            funct3_q;
  logic                  we_q;
  logic [1:0]            idx;
  logic [1:0]            last_idx;
  logic [3:0][7:0]       rd_buf;
  logic [31:0]           load_word;

  function automatic size_t decode(input logic we, input logic [2:0] f3);
    size_t s;
    s = '{valid: 1'b1, last: 2'd0};
    if (we) begin
      case (f3[1:0])
        2'b00:   s.last = 2'd0;
        2'b01:   s.last = 2'd1;
        2'b10:   s.last = 2'd3;
        default: s.valid = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: s.last = 2'd0;
        3'b001, 3'b101: s.last = 2'd1;
        3'b010:         s.last = 2'd3;
        default:        s.valid = 1'b0;
      endcase
    end
    return s;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'b0, w[7:0]};
      3'b101:  return {16'b0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // The final load byte arrives from the RAM during WAIT and bypasses the buffer.
  always_comb begin
    // NOTE: assign a full default before the partial overwrite so no latch is inferred.
    load_word           = rd_buf;
    load_word[last_idx*8 +: 8] = ram_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only control state and the visible response are reset; the datapath
      // registers are always loaded before they are used, so they need no reset.
      state      <= IDLE;
      resp_rdata <= '0;
      idx        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr[RAM_ADDR_W-1:0];
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            idx      <= '0;
            last_idx <= decode(req_we, req_funct3).last;
            if (decode(req_we, req_funct3).valid) begin
              state <= XFER;
            end else begin
              resp_rdata <= '0;
              state      <= DONE;
            end
          end
        end
        XFER: begin
          if (!we_q && idx != 2'd0) rd_buf[idx - 2'd1] <= ram_rdata;
          idx <= idx + 2'd1;
          if (idx == last_idx) state <= we_q ? DONE : WAIT;
        end
        WAIT: begin
          resp_rdata <= extend(funct3_q, load_word);
          state      <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = !rst && state == IDLE;
  assign stall_req  = !rst && ((state == IDLE && req_valid) || state == XFER || state == WAIT);
  assign resp_valid = state == DONE;
  assign ram_we     = state == XFER && we_q;
  assign ram_addr   = (state == XFER) ? addr_q + RAM_ADDR_W'(idx) : '0;
  assign ram_wdata  = ram_we ? wdata_q[idx*8 +: 8] : 8'h00;

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Randomized bench for mem_byte_ctrl: a byte RAM model plus a reference memory image
// predicts load data, write contents, latency and stall duration of every transaction.
module tb_mem_byte_ctrl;

  localparam int AW    = 17;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          req_ready;
  logic          stall_req;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  logic [7:0]    ram   [DEPTH];
  logic [7:0]    image [DEPTH];
  logic [31:0]   model_rdata;
  int            n_vec  = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  mem_byte_ctrl #(.RAM_ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .stall_req  (stall_req),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Synchronous byte RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int wrap(input logic [31:0] a);
    return int'(a & 32'(DEPTH - 1));
  endfunction

  // Number of bytes moved; 0 marks an invalid encoding.
  function automatic int byte_count(input logic we, input logic [2:0] f3);
    if (we) return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v = 0;
    int n = byte_count(1'b0, f3);
    for (int k = 0; k < n; k++) v = v + (32'(image[wrap(a + 32'(k))]) << (8 * k));
    if (f3 == 3'd0 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
    if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ram[wrap(a)]   = d;
    image[wrap(a)] = d;
  endtask

  task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    int          n      = byte_count(we, f3);
    int          lat    = (n == 0) ? 1 : (we ? n + 1 : n + 2);
    int          stalls = 0;
    int          c      = 0;
    bit          done   = 0;
    logic [31:0] exp_rd;
    exp_rd = (n == 0) ? 32'h0 : (we ? model_rdata : ref_load(f3, a));
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    #1;
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    check({tag, " idle resp_valid"}, 32'(resp_valid), 32'd0);
    while (!done && c < 20) begin
      if (stall_req) stalls++;
      @(negedge clk);
      c++;
      #1;
      if (resp_valid) begin
        done = 1;
        req_valid = 1'b0;
        check({tag, " latency"}, 32'(c), 32'(lat));
        check({tag, " rdata"}, resp_rdata, exp_rd);
        check({tag, " stall in done"}, 32'(stall_req), 32'd0);
      end else if (c <= n) begin
        check({tag, " ram_addr"}, 32'(ram_addr), 32'(wrap(a + 32'(c - 1))));
        check({tag, " ram_we"}, 32'(ram_we), 32'(we));
        if (we) check({tag, " ram_wdata"}, 32'(ram_wdata), (wd >> (8 * (c - 1))) & 32'hFF);
      end else begin
        check({tag, " idle ram_we"}, 32'(ram_we), 32'd0);
        check({tag, " idle ram_addr"}, 32'(ram_addr), 32'd0);
      end
    end
    if (!done) begin
      req_valid = 1'b0;
      check({tag, " timeout"}, 32'd0, 32'd1);
    end
    check({tag, " stall cycles"}, 32'(stalls), 32'(lat));
    if (n == 0) model_rdata = 32'h0;
    else if (!we) model_rdata = exp_rd;
    else begin
      for (int k = 0; k < n; k++) begin
        image[wrap(a + 32'(k))] = wd[8*k +: 8];
        check({tag, " ram byte"}, 32'(ram[wrap(a + 32'(k))]), 32'(wd[8*k +: 8]));
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]   = 8'($urandom);
      image[i] = ram[i];
    end
    model_rdata = 32'h0;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2;
    req_addr = 32'h100; req_wdata = 32'h0;

    // Reset holds off requests even with req_valid asserted.
    repeat (3) @(negedge clk);
    #1;
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst stall_req", 32'(stall_req), 32'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    check("post-rst resp_valid", 32'(resp_valid), 32'd0);
    check("post-rst resp_rdata", resp_rdata, 32'd0);
    check("post-rst ram_we", 32'(ram_we), 32'd0);
    check("post-rst ram_addr", 32'(ram_addr), 32'd0);
    check("post-rst ram_wdata", 32'(ram_wdata), 32'd0);
    check("post-rst req_ready", 32'(req_ready), 32'd1);
    check("post-rst stall_req", 32'(stall_req), 32'd0);

    // Directed cases.
    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    run_txn("lw 0x100", 1'b0, 3'd2, 32'h100, 32'h0);
    check("lw 0x100 value", model_rdata, 32'h4433_2211);
    poke(32'h300, 8'h80);
    run_txn("lb 0x80", 1'b0, 3'd0, 32'h300, 32'h0);
    check("lb value", model_rdata, 32'hFFFF_FF80);
    run_txn("lbu 0x80", 1'b0, 3'd4, 32'h300, 32'h0);
    check("lbu value", model_rdata, 32'h0000_0080);
    poke(32'h310, 8'h01); poke(32'h311, 8'h80);
    run_txn("lh 0x8001", 1'b0, 3'd1, 32'h310, 32'h0);
    check("lh value", model_rdata, 32'hFFFF_8001);
    run_txn("sh misaligned", 1'b1, 3'd1, 32'h203, 32'hDEAD_BEEF);
    run_txn("lw wrap", 1'b0, 3'd2, 32'(DEPTH - 2), 32'h0);

    // Store interrupted by reset after two bytes.
    a = 32'h400;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = a; req_wdata = 32'h0102_0304;
    @(negedge clk); #1;
    check("sw-rst byte0 we", 32'(ram_we), 32'd1);
    check("sw-rst byte0 data", 32'(ram_wdata), 32'h04);
    @(negedge clk); rst = 1'b1; #1;
    check("sw-rst byte1 data", 32'(ram_wdata), 32'h03);
    check("sw-rst stall in rst", 32'(stall_req), 32'd0);
    check("sw-rst ready in rst", 32'(req_ready), 32'd0);
    @(negedge clk); rst = 1'b0; req_valid = 1'b0; #1;
    check("sw-rst resp_valid", 32'(resp_valid), 32'd0);
    check("sw-rst resp_rdata", resp_rdata, 32'd0);
    check("sw-rst ram_we", 32'(ram_we), 32'd0);
    check("sw-rst ram_addr", 32'(ram_addr), 32'd0);
    check("sw-rst ram_wdata", 32'(ram_wdata), 32'd0);
    image[wrap(a)] = 8'h04; image[wrap(a + 1)] = 8'h03;
    model_rdata = 32'h0;
    for (int k = 0; k < 4; k++) check("sw-rst ram byte", 32'(ram[wrap(a + 32'(k))]), 32'(image[wrap(a + 32'(k))]));
    run_txn("lw after rst", 1'b0, 3'd2, a, 32'h0);

    run_txn("invalid 011", 1'b0, 3'd3, 32'h100, 32'h0);
    run_txn("lw after invalid", 1'b0, 3'd2, 32'h100, 32'h0);

    // Randomized traffic, biased toward the top of the RAM to exercise wrap.
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = (a & ~32'(DEPTH - 1)) | 32'(DEPTH - int'($urandom_range(1, 4)));
      run_txn("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_byte_ctrl.md
# mem_byte_ctrl

Memory-access engine between the MEM pipeline stage and a byte-wide synchronous data RAM. It accepts one load or store request per transaction, issues it as 1, 2 or 4 consecutive byte accesses in little-endian order, and holds the pipeline with a stall request until the transaction finishes. It returns sign- or zero-extended load data on a one-cycle completion pulse.

## Interface

- RAM_ADDR_W, default 17: width of the RAM byte address. Request addresses are truncated to this width.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  MEM stage presents a memory operation; held stable while stall_req=1.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores decode [1:0] only.
- req_addr  in  32  byte address (effective address from EX).
- req_wdata  in  32  store data; the low bytes are used.
- req_ready  out  1  FSM idle; a request is accepted this cycle if req_valid=1.
- stall_req  out  1  freeze IF..MEM stages.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; held until the next completion.
- ram_addr  out  RAM_ADDR_W  byte address to the RAM.
- ram_we  out  1  byte write strobe.
- ram_wdata  out  8  write byte.
- ram_rdata  in  8  read byte, valid the cycle after its address was presented.

## Operation

- States: IDLE, XFER, WAIT, DONE.
- Byte count n:
  - B/BU = 1, H/HU = 2, W = 4.
  - Invalid encodings are 011, 110, 111 for loads and [1:0]=11 for stores.
- IDLE:
  - req_ready=1.
  - If req_valid, latch addr, wdata, funct3 and we, clear idx, and go to XFER.
  - Invalid encoding: go straight to DONE with n=0. No RAM access occurs and resp_rdata=0.
- XFER, one byte per cycle:
  - ram_addr = (addr + idx) mod 2^RAM_ADDR_W. Misaligned accesses are allowed and wrap at the top of the RAM.
  - Store: ram_we=1, ram_wdata = wdata byte idx.
  - Load: ram_we=0. Capture ram_rdata into buffer byte idx-1 when idx>0.
  - Increment idx. After byte n-1: a store goes to DONE, a load goes to WAIT.
- WAIT (loads only): capture ram_rdata into buffer byte n-1, then go to DONE.
- DONE:
  - resp_valid=1. resp_rdata is registered at the DONE transition.
  - Then return to IDLE. Any req_valid seen while in DONE is ignored.
- Load extension: B sign-extends bit 7, H sign-extends bit 15, BU/HU zero-extend, W is passed through.
- A completed store also pulses resp_valid. resp_rdata is unchanged on a store.
- stall_req = (IDLE and req_valid) or XFER or WAIT.
  - It is 0 in DONE, so the pipeline advances exactly in the resp_valid cycle.
  - The requester must present the next request (or req_valid=0) from the following cycle.
- Outside XFER: ram_we=0, ram_addr=0, ram_wdata=0.
- At most one transaction is in flight; there is no queueing.

## Timing

- Request accepted in IDLE at cycle T.
- Load of n bytes:
  - XFER at T+1..T+n, WAIT at T+n+1.
  - resp_valid at T+n+2.
  - stall_req high for T..T+n+1 (n+2 cycles).
- Store of n bytes:
  - ram_we high at T+1..T+n.
  - resp_valid at T+n+1.
- Invalid encoding: resp_valid at T+1, stall_req high for T only.
- Back-to-back: the next accept can happen no earlier than the resp_valid cycle +1.
- Reset, including mid-transaction:
  - Next state IDLE. Abandoned bytes are not completed; bytes already written stay written.
  - resp_valid=0, resp_rdata=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - While rst=1: req_ready=0 and stall_req=0, and requests are ignored.

## Test plan

- LW at 0x100, RAM[0x100..0x103] = 11,22,33,44 → ram_addr 0x100..0x103 at T+1..T+4, resp_rdata=0x44332211 with resp_valid at T+6, stall_req high for exactly T..T+5.
- LB and LBU at a byte holding 0x80 → 0xFFFFFF80 and 0x00000080 respectively, resp_valid at T+3. LH of 0x8001 → 0xFFFF8001.
- SH req_wdata=0xDEADBEEF at 0x203 (misaligned) → ram_we at T+1 (0x203, 0xEF) and T+2 (0x204, 0xBE), resp_valid at T+3, resp_rdata unchanged.
- LW at address 2^RAM_ADDR_W−2 → byte addresses wrap: max−1, max, 0, 1. Data assembled in that order.
- SW 0x01020304 with rst asserted at T+2 → only 0x04 and 0x03 written, no resp_valid, all outputs at reset values next cycle, then the next LW works normally.
- Load with funct3=011 → no ram_we, no RAM address change, resp_valid at T+1 with resp_rdata=0. An LW immediately following completes correctly with no overlap.
